// File: rtl/arith_loop_monitor_if.sv
// Bus between the x/y accumulator harness and the loop monitor.
// master: harness side (drives the sampled accumulator outputs)
// slave:  monitor side (returns status and progress)
interface arith_loop_monitor_if #(
  parameter int W  = 15,
  parameter int SW = 16
);
  logic          selector;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [1:0]    state;
  logic          done;
  logic          err;
  logic [2:0]    err_code;
  logic [W-1:0]  err_y;
  logic [W-1:0]  steps;
  logic [SW-1:0] stall_cnt;

  modport master (
    output selector, x, y,
    input  state, done, err, err_code, err_y, steps, stall_cnt
  );

  modport slave (
    input  selector, x, y,
    output state, done, err, err_code, err_y, steps, stall_cnt
  );
endinterface

// File: rtl/arith_loop_monitor.sv
// Shadow-model checker for the selector-gated x/y accumulator loop.
// Tracks its own copy of x/y, flags divergence or a broken terminal
// property, and reports steps, stalls and completion.
module arith_loop_monitor #(
  parameter int W     = 15,
  parameter int LIMIT = 200,
  parameter int SW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  arith_loop_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam logic [W-1:0] LIM = W'(LIMIT);

  state_e        state_q, state_d;
  logic [W-1:0]  sx_q, sx_d;
  logic [W-1:0]  sy_q, sy_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;
  logic [W-1:0]  erry_q, erry_d;
  logic          done_q, done_d;

  logic          mx, my, pv, adv;
  logic [W-1:0]  sy_inc;

  // Stall counter increment that sticks at all-ones.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == {SW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign mx     = (bus.x != sx_q);
  assign my     = (bus.y != sy_q);
  assign pv     = (bus.y >= LIM) && (bus.x < bus.y);
  assign adv    = bus.selector && (sy_q < LIM);
  assign sy_inc = sy_q + 1'b1;

  // Next state: errors take priority; ERR freezes everything.
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    stall_d = stall_q;
    err_d   = err_q;
    code_d  = code_q;
    erry_d  = erry_q;
    if (state_q != ERR) begin
      if (mx || my || pv) begin
        state_d = ERR;
        err_d   = 1'b1;
        code_d  = {pv, my, mx};
        erry_d  = bus.y;
      end else if (state_q != DONE) begin
        if (adv) begin
          sx_d    = sx_q + sy_q;
          sy_d    = sy_inc;
          state_d = (sy_inc == LIM) ? DONE : RUN;
        end else if (state_q == RUN) begin
          stall_d = sat_inc(stall_q);
        end
      end
    end
    done_d = (state_d == DONE);
  end

  // State register; reset restores the initial loop values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sx_q    <= W'(1);
      sy_q    <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      erry_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      code_q  <= code_d;
      erry_q  <= erry_d;
      done_q  <= done_d;
    end
  end

  // Steps equals the shadow y: one advance per y increment.
  assign bus.state     = state_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.err_y     = erry_q;
  assign bus.steps     = sy_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_arith_loop_monitor.sv
// Bench for arith_loop_monitor: plays the accumulator, keeps a
// behavioural model of the monitor and compares every cycle.
module tb_arith_loop_monitor;
  localparam int W     = 15;
  localparam int LIMIT = 200;
  localparam int SW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arith_loop_monitor_if #(.W(W), .SW(SW)) bus ();

  arith_loop_monitor #(.W(W), .LIMIT(LIMIT), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Accumulator being impersonated
  int acc_x, acc_y;

  // Behavioural model of the monitor outputs
  int m_state, m_sx, m_sy, m_stall, m_err, m_code, m_erry;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the monitor must hold after this edge
  always @(posedge clk) begin
    int xv, yv, sel, f;
    xv = int'(bus.x); yv = int'(bus.y); sel = int'(bus.selector);
    if (rst) begin
      m_state = 0; m_sx = 1; m_sy = 0; m_stall = 0;
      m_err = 0; m_code = 0; m_erry = 0;
    end else if (m_state != 3) begin
      f = (xv != m_sx ? 1 : 0) | (yv != m_sy ? 2 : 0) |
          ((yv >= LIMIT && xv < yv) ? 4 : 0);
      if (f != 0) begin
        m_state = 3; m_err = 1; m_code = f; m_erry = yv;
      end else if (m_state != 2) begin
        if (sel == 1 && m_sy < LIMIT) begin
          m_sx = (m_sx + m_sy) % (1 << W);
          m_sy = m_sy + 1;
          m_state = (m_sy == LIMIT) ? 2 : 1;
        end else if (m_state == 1 && m_stall < (1 << SW) - 1) begin
          m_stall = m_stall + 1;
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     32'(bus.state),     32'(m_state));
      chk("done",      32'(bus.done),      (m_state == 2) ? 32'd1 : 32'd0);
      chk("err",       32'(bus.err),       32'(m_err));
      chk("err_code",  32'(bus.err_code),  32'(m_code));
      chk("err_y",     32'(bus.err_y),     32'(m_erry));
      chk("steps",     32'(bus.steps),     32'(m_sy));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    end
  end

  task automatic drive(input bit sel, input int xv, input int yv);
    bus.selector = sel;
    bus.x = W'(xv);
    bus.y = W'(yv);
  endtask

  task automatic do_reset(input bit sel);
    rst = 1'b1;
    acc_x = 1; acc_y = 0;
    drive(sel, acc_x, acc_y);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One cycle of a well-behaved accumulator
  task automatic tick(input bit sel);
    drive(sel, acc_x, acc_y);
    @(posedge clk);
    if (sel && acc_y < LIMIT) begin
      acc_x = acc_x + acc_y;
      acc_y = acc_y + 1;
    end
    #1;
  endtask

  // One cycle with arbitrary sampled values
  task automatic tick_raw(input bit sel, input int xv, input int yv);
    drive(sel, xv, yv);
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 4 * LIMIT && acc_y < LIMIT; i++) tick(1'b1);
  endtask

  initial begin
    int pat [6] = '{1, 0, 0, 1, 1, 0};
    drive(1'b0, 1, 0);

    // Reset state
    do_reset(1'b0);
    chk_en = 1'b1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_steps", 32'(bus.steps), 32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);

    // 1: continuous selector
    run_to_done();
    tick(1'b1);
    chk("t1_state", 32'(bus.state),     32'd2);
    chk("t1_done",  32'(bus.done),      32'd1);
    chk("t1_steps", 32'(bus.steps),     32'd200);
    chk("t1_stall", 32'(bus.stall_cnt), 32'd0);
    chk("t1_err",   32'(bus.err),       32'd0);
    chk("t1_x",     32'(acc_x),         32'd19901);
    chk("t1_msx",   32'(m_sx),          32'd19901);

    // 6: selector toggled in DONE, x/y held
    for (int i = 0; i < 50; i++) tick(i[0]);
    chk("t6_state", 32'(bus.state),     32'd2);
    chk("t6_steps", 32'(bus.steps),     32'd200);
    chk("t6_stall", 32'(bus.stall_cnt), 32'd0);
    chk("t6_err",   32'(bus.err),       32'd0);

    // 4: property violation with consistent y in DONE
    tick_raw(1'b1, 5, 200);
    chk("t4_state", 32'(bus.state),    32'd3);
    chk("t4_code",  32'(bus.err_code), 32'b101);
    chk("t4_erry",  32'(bus.err_y),    32'd200);
    chk("t4_done",  32'(bus.done),     32'd0);

    // 2: stall pattern, with idle low cycles first
    do_reset(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("t2_idle_stall", 32'(bus.stall_cnt), 32'd0);
    chk("t2_idle_state", 32'(bus.state),     32'd0);
    for (int i = 0; i < 1000 && acc_y < LIMIT; i++) tick(pat[i % 6] != 0);
    chk("t2_state", 32'(bus.state),     32'd2);
    chk("t2_steps", 32'(bus.steps),     32'd200);
    chk("t2_stall", 32'(bus.stall_cnt), 32'd200);
    chk("t2_err",   32'(bus.err),       32'd0);

    // 3: x corrupted at y=37, then y mismatches
    do_reset(1'b1);
    for (int i = 0; i < 37; i++) tick(1'b1);
    tick_raw(1'b1, acc_x + 1, acc_y);
    chk("t3_state", 32'(bus.state),    32'd3);
    chk("t3_code",  32'(bus.err_code), 32'b001);
    chk("t3_erry",  32'(bus.err_y),    32'd37);
    for (int i = 0; i < 4; i++) tick_raw(1'b1, acc_x, 99 + i);
    chk("t3_code2",  32'(bus.err_code), 32'b001);
    chk("t3_steps2", 32'(bus.steps),    32'd37);
    chk("t3_erry2",  32'(bus.err_y),    32'd37);
    chk("t3_err2",   32'(bus.err),      32'd1);

    // 5: reset mid-run at y=120, then full run
    do_reset(1'b1);
    for (int i = 0; i < 120; i++) tick(1'b1);
    chk("t5_pre_steps", 32'(bus.steps), 32'd120);
    chk("t5_pre_state", 32'(bus.state), 32'd1);
    do_reset(1'b1);
    chk("t5_state", 32'(bus.state),    32'd0);
    chk("t5_steps", 32'(bus.steps),    32'd0);
    chk("t5_err",   32'(bus.err),      32'd0);
    chk("t5_code",  32'(bus.err_code), 32'd0);
    run_to_done();
    tick(1'b1);
    chk("t5_done",  32'(bus.done),  32'd1);
    chk("t5_steps2", 32'(bus.steps), 32'd200);
    chk("t5_x",     32'(acc_x),     32'd19901);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arith_loop_monitor.md
Name: arith_loop_monitor

Overview:
- Downstream checker for the selector-gated x/y accumulator (x <= x+y, y <= y+1 while selector && y<LIMIT).
- Samples the accumulator's x/y outputs and selector every clock, and keeps its own shadow model of the loop.
- Flags divergence and violations of the terminal property !(y>=LIMIT && x<y).
- Reports progress (steps, stalls, done) for the property-mining harness; sits beside the accumulator on the same clk/rst.

Parameters:
- W, 15, width of x, y, shadow registers and step counter.
- LIMIT, 200, y bound; advance allowed only while y < LIMIT.
- SW, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- selector  input  1  same selector that drives the accumulator.
- x  input  W  accumulator x output.
- y  input  W  accumulator y output.
- state  output  2  00 IDLE, 01 RUN, 10 DONE, 11 ERR.
- done  output  1  high while state==DONE.
- err  output  1  sticky error flag.
- err_code  output  3  bit0 x mismatch, bit1 y mismatch, bit2 property violation; latched at first error.
- err_y  output  W  sampled y at first error.
- steps  output  W  count of advances (equals shadow y).
- stall_cnt  output  SW  RUN cycles with selector low; saturates at all-ones.

Behaviour:
- Reset (rst=1 at posedge):
  - shadow sx=1, sy=0, state=IDLE, done=0, err=0, err_code=0, err_y=0, steps=0, stall_cnt=0.
  - No checks are performed in a reset cycle.
  - Reset mid-operation (any state, including ERR) returns everything to these values.
- Alignment: monitor and accumulator reset on the same edge, so at every posedge with rst=0 the sampled x/y must equal sx/sy.
- Checks at each non-reset posedge, all evaluated on sampled values:
  - mx = (x != sx)
  - my = (y != sy)
  - pv = (y >= LIMIT) && (x < y)
- adv = selector && (sy < LIMIT).
- Shadow update, when state != ERR and no check fails:
  - if adv: sx <= sx + sy (W-bit wrap), sy <= sy + 1, steps <= steps + 1;
  - otherwise hold.
- Error entry:
  - Any of mx/my/pv -> state <= ERR, err <= 1, err_code <= {pv,my,mx}, err_y <= y.
  - Error has priority over all other transitions.
- ERR is sticky:
  - err_code, err_y, steps, sx/sy and stall_cnt freeze.
  - Further mismatches do not overwrite err_code.
- FSM (non-error cases):
  - IDLE: adv -> RUN, or directly -> DONE if LIMIT==1; !selector -> stay IDLE (no stall counted in IDLE).
  - RUN: adv with sy+1==LIMIT -> DONE; adv otherwise -> RUN; !selector -> RUN with stall_cnt+1 (saturating).
  - DONE: stay. Selector ignored; no stalls counted. Checks continue, so a later mismatch still -> ERR.
- done is registered: it rises on the same edge that state enters DONE.
- Latency: all outputs registered. A bad sample at edge k is visible on err/state after edge k.
- W-bit wrap of sx is intentional; with defaults the maximum sx is 19901 < 2^15, so no wrap occurs.
- Simultaneous events:
  - rst beats everything.
  - Error beats DONE entry on the same edge.
  - A stall and an error on the same edge: error wins, stall not counted.

Test Plan:
1. rst 1 cycle, selector=1 continuously, bench model drives correct x/y -> after 200 advances: state=DONE, done=1, steps=200, sampled x=19901, y=200, err=0, stall_cnt=0.
2. selector pattern 1,0,0,1,1,0 repeating until DONE -> done after 200 advances; stall_cnt equals the count of RUN cycles with selector=0; x/y always match; err=0.
3. Bench forces x=sx+1 at y=37 -> next edge: state=ERR, err_code=001, err_y=37. Subsequent y mismatches leave err_code=001 and steps=37.
4. Bench drives x=5, y=200 with sy=200 (consistent shadow in DONE) -> err_code bit2 set, state=ERR, err_y=200.
5. rst asserted at y=120 in RUN, then selector=1 -> all outputs back to reset values; full run to DONE completes again with x=19901.
6. In DONE, selector toggled for 50 cycles with x/y held -> state stays DONE, steps=200, stall_cnt unchanged, err=0.
